// File: rtl/pipe_stage_decoupler_pkg.sv
// Shared defaults for the writeback pipeline decoupler.
// Holds the payload field widths and the packed payload width.
package pipe_stage_decoupler_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_REGDST_WIDTH = 7;
    localparam int DEF_CNT_WIDTH    = 16;

    // Packed payload order is {dataD, w, regDst, MuxD, RF_wrd}.
    function automatic int payload_width(input int dw = DEF_DATA_WIDTH,
                                         input int rw = DEF_REGDST_WIDTH);
        return 2 * dw + rw + 2;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded payload register without reset.
// The matching valid bit lives in the parent.
module pipe_payload_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // NOTE: payload is qualified by a separately reset valid bit, so leaving it
    // unreset is safe and lets it map onto plain enable flops.
    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_decoupler.sv
// Two-entry skid buffer between the memory stage and writeback.
// in_ready is registered, so out_ready never reaches it combinationally.
module pipe_stage_decoupler
    import pipe_stage_decoupler_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int REGDST_WIDTH = DEF_REGDST_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_dataD,
    input  logic [DATA_WIDTH-1:0]   in_w,
    input  logic [REGDST_WIDTH-1:0] in_regDst,
    input  logic                    in_MuxD,
    input  logic                    in_RF_wrd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_dataD,
    output logic [DATA_WIDTH-1:0]   out_w,
    output logic [REGDST_WIDTH-1:0] out_regDst,
    output logic                    out_MuxD,
    output logic                    out_RF_wrd,
    output logic [1:0]              occupancy,
    output logic [CNT_WIDTH-1:0]    stall_cnt
);

    localparam int PW = payload_width(DATA_WIDTH, REGDST_WIDTH);

    logic                 main_valid_q, main_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 main_load, skid_load;
    logic                 accept, transfer, main_free;
    logic                 main_rf_wrd;
    logic [PW-1:0]        in_payload, main_payload, skid_payload, main_payload_nxt;

    assign in_payload = {in_dataD, in_w, in_regDst, in_MuxD, in_RF_wrd};

    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign transfer  = main_valid_q & out_ready;
    assign main_free = ~main_valid_q | transfer;

    // NOTE: every signal is given a default before the branches, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_load    = 1'b0;
        skid_load    = 1'b0;

        if (main_free) begin
            // A waiting skid entry always goes first to keep acceptance order.
            main_valid_d = skid_valid_q | accept;
            main_load    = skid_valid_q | accept;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_load    = 1'b1;
        end

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_load    = 1'b0;
            skid_load    = 1'b0;
        end
    end

    assign main_payload_nxt = skid_valid_q ? skid_payload : in_payload;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    pipe_payload_reg #(.WIDTH(PW)) u_main_reg (
        .clk    (clk),
        .load_i (main_load),
        .d_i    (main_payload_nxt),
        .q_o    (main_payload)
    );

    pipe_payload_reg #(.WIDTH(PW)) u_skid_reg (
        .clk    (clk),
        .load_i (skid_load),
        .d_i    (in_payload),
        .q_o    (skid_payload)
    );

    assign {out_dataD, out_w, out_regDst, out_MuxD, main_rf_wrd} = main_payload;

    assign out_valid  = main_valid_q;
    assign out_RF_wrd = main_rf_wrd & main_valid_q;
    assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_decoupler.sv
// Bench for pipe_stage_decoupler: directed scenarios plus random traffic
// checked against a queue model of the buffered entries.
module tb_pipe_stage_decoupler;

    localparam int DW = 32;
    localparam int RW = 7;
    localparam int CW = 4;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_dataD = '0;
    logic [DW-1:0] in_w = '0;
    logic [RW-1:0] in_regDst = '0;
    logic          in_MuxD = 1'b0;
    logic          in_RF_wrd = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_dataD;
    logic [DW-1:0] out_w;
    logic [RW-1:0] out_regDst;
    logic          out_MuxD;
    logic          out_RF_wrd;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [DW-1:0] w;
        logic [RW-1:0] r;
        logic          m;
        logic          f;
    } ent_t;

    ent_t mq[$];
    int   exp_stall = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    pipe_stage_decoupler #(
        .DATA_WIDTH   (DW),
        .REGDST_WIDTH (RW),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dataD   (in_dataD),
        .in_w       (in_w),
        .in_regDst  (in_regDst),
        .in_MuxD    (in_MuxD),
        .in_RF_wrd  (in_RF_wrd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dataD  (out_dataD),
        .out_w      (out_w),
        .out_regDst (out_regDst),
        .out_MuxD   (out_MuxD),
        .out_RF_wrd (out_RF_wrd),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

    function automatic ent_t mk(input logic [DW-1:0] d, input logic [RW-1:0] r, input logic f);
        ent_t e;
        e.d = d;
        e.w = ~d;
        e.r = r;
        e.m = d[0];
        e.f = f;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.d = $urandom;
        e.w = $urandom;
        e.r = RW'($urandom);
        e.m = 1'($urandom);
        e.f = 1'($urandom);
        return e;
    endfunction

    task automatic drive(input logic v, input ent_t e);
        in_valid  = v;
        in_dataD  = e.d;
        in_w      = e.w;
        in_regDst = e.r;
        in_MuxD   = e.m;
        in_RF_wrd = e.f;
    endtask

    // Advance one clock: model decisions use the inputs seen before the edge.
    task automatic tick();
        logic acc, xfer;
        ent_t e;
        acc  = in_valid && (mq.size() < 2);
        xfer = (mq.size() > 0) && out_ready;
        e.d = in_dataD; e.w = in_w; e.r = in_regDst; e.m = in_MuxD; e.f = in_RF_wrd;
        if (mq.size() > 0 && !out_ready && exp_stall < STALL_MAX) exp_stall++;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (xfer) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, mk('0, '0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        exp_stall = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        tests_run++;
        if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        tests_run++;
        if (out_RF_wrd !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_wrd: got %0b want 0", out_RF_wrd); end
        tests_run++;
        if (stall_cnt !== '0) begin tests_failed++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        exp_stall = 0;
    endtask

    task automatic test_single();
        ent_t e;
        e = mk(32'h1234_5678, 7'd5, 1'b1);
        out_ready = 1'b1;
        drive(1'b1, e);
        tick();
        drive(1'b0, e);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        tests_run++;
        if (out_dataD !== 32'h1234_5678) begin tests_failed++; $display("FAIL single_dataD: got %h want 12345678", out_dataD); end
        tests_run++;
        if (out_regDst !== 7'd5 || out_w !== e.w || out_MuxD !== e.m) begin
            tests_failed++; $display("FAIL single_fields: got regDst=%0d w=%h mux=%0b want regDst=5 w=%h mux=%0b",
                                     out_regDst, out_w, out_MuxD, e.w, e.m);
        end
        tests_run++;
        if (out_RF_wrd !== 1'b1) begin tests_failed++; $display("FAIL single_rf_wrd: got %0b want 1", out_RF_wrd); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_RF_wrd !== 1'b0) begin
            tests_failed++; $display("FAIL single_drain: got valid=%0b rf=%0b want 0 0", out_valid, out_RF_wrd);
        end
    endtask

    task automatic test_back_pressure();
        ent_t a, b, c;
        logic [DW-1:0] got[$];
        logic [DW-1:0] want[3];
        logic [DW-1:0] obs;
        logic will_acc;
        do_reset();
        a = mk(32'hA0A0_0001, 7'd1, 1'b1);
        b = mk(32'hB0B0_0002, 7'd2, 1'b0);
        c = mk(32'hC0C0_0003, 7'd3, 1'b1);
        want[0] = a.d; want[1] = b.d; want[2] = c.d;
        drive(1'b1, a); tick();
        drive(1'b1, b); tick();
        tests_run++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
            tests_failed++; $display("FAIL bp_full: got in_ready=%0b occ=%0d want 0 2", in_ready, occupancy);
        end
        tests_run++;
        if (out_dataD !== a.d) begin tests_failed++; $display("FAIL bp_head: got %h want %h", out_dataD, a.d); end
        drive(1'b1, c); tick();
        tests_run++;
        if (occupancy !== 2'd2 || out_dataD !== a.d) begin
            tests_failed++; $display("FAIL bp_hold: got occ=%0d head=%h want 2 %h", occupancy, out_dataD, a.d);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && got.size() < 3; i++) begin
            if (out_valid) got.push_back(out_dataD);
            will_acc = in_valid && (mq.size() < 2);
            tick();
            if (will_acc) in_valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            obs = (i < got.size()) ? got[i] : 'x;
            tests_run++;
            if (obs !== want[i]) begin tests_failed++; $display("FAIL bp_order[%0d]: got %h want %h", i, obs, want[i]); end
        end
    endtask

    task automatic test_streaming();
        int xfers;
        int order_errs;
        do_reset();
        out_ready = 1'b1;
        xfers = 0;
        order_errs = 0;
        for (int cyc = 0; cyc < 101; cyc++) begin
            if (out_valid) begin
                if (out_dataD !== 32'h1000 + xfers) order_errs++;
                xfers++;
            end
            if (cyc < 100) drive(1'b1, mk(32'h1000 + cyc, RW'(cyc), 1'b1));
            else drive(1'b0, mk('0, '0, 1'b0));
            tick();
        end
        tests_run++;
        if (xfers != 100) begin tests_failed++; $display("FAIL stream_count: got %0d transfers want 100", xfers); end
        tests_run++;
        if (order_errs != 0) begin tests_failed++; $display("FAIL stream_order: got %0d misordered want 0", order_errs); end
        tests_run++;
        if (stall_cnt !== '0) begin tests_failed++; $display("FAIL stream_stall: got %0d want 0", stall_cnt); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_empty: got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        logic seen;
        do_reset();
        drive(1'b1, mk(32'h1111_1111, 7'd11, 1'b1)); tick();
        drive(1'b1, mk(32'h2222_2222, 7'd22, 1'b1)); tick();
        tests_run++;
        if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
        flush = 1'b1;
        drive(1'b1, mk(32'hDEAD_BEEF, 7'd99, 1'b1));
        tick();
        flush = 1'b0;
        drive(1'b0, mk('0, '0, 1'b0));
        tests_run++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_RF_wrd !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_clear: got valid=%0b occ=%0d in_ready=%0b rf=%0b want 0 0 1 0",
                     out_valid, occupancy, in_ready, out_RF_wrd);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL flush_ghost: got a flushed entry delivered want none"); end
    endtask

    task automatic test_stall_sat();
        do_reset();
        drive(1'b1, mk(32'h5A5A_5A5A, 7'd7, 1'b1));
        tick();
        drive(1'b0, mk('0, '0, 1'b0));
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 5) begin
                tests_run++;
                if (stall_cnt !== 4'd5) begin tests_failed++; $display("FAIL stall_count5: got %0d want 5", stall_cnt); end
            end
        end
        tests_run++;
        if (stall_cnt !== 4'd15) begin tests_failed++; $display("FAIL stall_saturate: got %0d want 15", stall_cnt); end
    endtask

    task automatic test_async_reset();
        ent_t e;
        do_reset();
        drive(1'b1, mk(32'h3333_0001, 7'd1, 1'b1)); tick();
        drive(1'b1, mk(32'h3333_0002, 7'd2, 1'b1)); tick();
        drive(1'b0, mk('0, '0, 1'b0));
        tests_run++;
        if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL arst_pre_occ: got %0d want 2", occupancy); end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_RF_wrd !== 1'b0 || stall_cnt !== '0) begin
            tests_failed++;
            $display("FAIL arst_clear: got valid=%0b occ=%0d in_ready=%0b rf=%0b stall=%0d want 0 0 1 0 0",
                     out_valid, occupancy, in_ready, out_RF_wrd, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        exp_stall = 0;
        e = mk(32'h4444_4444, 7'd4, 1'b1);
        out_ready = 1'b1;
        drive(1'b1, e);
        tick();
        drive(1'b0, e);
        tests_run++;
        if (out_valid !== 1'b1 || out_dataD !== e.d) begin
            tests_failed++; $display("FAIL arst_resume: got valid=%0b data=%h want 1 %h", out_valid, out_dataD, e.d);
        end
        tick();
    endtask

    task automatic test_random();
        ent_t obs;
        logic exp_v;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_v = mq.size() > 0;
            obs = {out_dataD, out_w, out_regDst, out_MuxD, out_RF_wrd};
            tests_run++;
            if (out_valid !== exp_v || occupancy !== 2'(mq.size()) || in_ready !== (mq.size() < 2)) begin
                tests_failed++;
                $display("FAIL rand_ctrl@%0d: got valid=%0b occ=%0d in_ready=%0b want %0b %0d %0b",
                         cyc, out_valid, occupancy, in_ready, exp_v, mq.size(), mq.size() < 2);
            end
            tests_run++;
            if (exp_v && obs !== mq[0]) begin
                tests_failed++; $display("FAIL rand_payload@%0d: got %h want %h", cyc, obs, mq[0]);
            end
            tests_run++;
            if (!exp_v && out_RF_wrd !== 1'b0) begin
                tests_failed++; $display("FAIL rand_rf_idle@%0d: got %0b want 0", cyc, out_RF_wrd);
            end
            tests_run++;
            if (stall_cnt !== CW'(exp_stall)) begin
                tests_failed++; $display("FAIL rand_stall@%0d: got %0d want %0d", cyc, stall_cnt, exp_stall);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            drive(1'($urandom), rand_ent());
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_back_pressure();
        test_streaming();
        test_flush();
        test_stall_sat();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_decoupler.md
PIPE_STAGE_DECOUPLER -- requirements
Module: pipe_stage_decoupler

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of dataD and w fields.
REQ-002 Parameter REGDST_WIDTH, default 7, width of regDst field.
REQ-003 Parameter CNT_WIDTH, default 16, width of stall counter.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 flush  input  1  discard all held and incoming entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  block can accept an entry.
REQ-009 in_dataD, in_w  input  DATA_WIDTH each  payload data fields.
REQ-010 in_regDst  input  REGDST_WIDTH  destination register.
REQ-011 in_MuxD, in_RF_wrd  input  1 each  writeback mux select, register-file write enable.
REQ-012 out_valid  output  1  downstream entry present.
REQ-013 out_ready  input  1  downstream accepts entry.
REQ-014 out_dataD, out_w, out_regDst, out_MuxD, out_RF_wrd  output  widths as inputs  payload to writeback.
REQ-015 occupancy  output  2  entries held (0..2).
REQ-016 stall_cnt  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; each has a valid bit.
REQ-018 Accept SHALL occur when in_valid=1 and in_ready=1; transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL equal NOT skid_valid, driven from a register (no combinational path from out_ready).
REQ-020 out_valid SHALL equal main_valid; out_dataD/out_w/out_regDst/out_MuxD SHALL be the main payload registers.
REQ-021 out_RF_wrd SHALL be main_RF_wrd AND main_valid, so an invalid slot never requests a write.
REQ-022 When main is empty or a transfer occurs: main SHALL load skid if skid_valid, else the accepted input, else become empty.
REQ-023 When main is full and no transfer occurs, an accepted input SHALL load skid.
REQ-024 When skid moves to main, skid SHALL become empty; an input accepted that cycle SHALL load main only if skid was empty, otherwise impossible (in_ready=0).
REQ-025 Entries SHALL leave in acceptance order; none duplicated or lost except by flush.
REQ-026 Latency: an entry accepted into an empty block SHALL appear at out_valid the next cycle; sustained throughput one entry per cycle when out_ready=1.
REQ-027 flush=1 SHALL clear main_valid and skid_valid at the next edge, overriding all loads; an input accepted in that cycle SHALL be discarded; a transfer in that cycle SHALL count as completed.
REQ-028 Payload registers SHALL load only with their valid bit; when empty they hold their last value.
REQ-029 occupancy SHALL equal main_valid + skid_valid.
REQ-030 stall_cnt SHALL increment by 1 each cycle out_valid=1 and out_ready=0, saturating at all-ones; unaffected by flush.

Reset
REQ-031 rst=1 SHALL immediately clear main_valid, skid_valid and stall_cnt, giving out_valid=0, out_RF_wrd=0, in_ready=1, occupancy=0.
REQ-032 Payload registers SHALL not be reset; rst asserted mid-transfer SHALL drop all held entries.

Structure
REQ-033 Shared package SHALL hold default DATA_WIDTH, REGDST_WIDTH and the payload width sum (2*DATA_WIDTH+REGDST_WIDTH+2).
REQ-034 Sub-module pipe_payload_reg (enable-loaded, non-reset payload register, width-parameterised) SHALL be instantiated twice (main, skid).

Verification
REQ-035 Single entry: in_dataD=0x12345678, regDst=5, RF_wrd=1, out_ready=1 -> out_valid=1 next cycle with identical payload, then out_valid=0.
REQ-036 Back-pressure: three back-to-back inputs A,B,C, out_ready=0 -> A in main, B in skid, in_ready=0 after B, C held upstream, occupancy=2; release out_ready -> A,B,C delivered in order.
REQ-037 Streaming: 100 entries, out_ready=1 continuously -> 100 transfers in 101 cycles, order preserved, stall_cnt=0.
REQ-038 Flush with occupancy=2 and in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, out_RF_wrd=0, flushed input never appears.
REQ-039 Stall counter: CNT_WIDTH=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15.
REQ-040 Asynchronous reset asserted mid-cycle with occupancy=2 -> outputs cleared before next clk edge; operation resumes normally after deassert.
